// File: rtl/stream_stats_monitor.sv
// stream_stats_monitor: per-channel statistics and a recent-sample FIFO for a
// tagged sample stream.
//   clk, rst           clock; synchronous active-high reset
//   s_valid/s_ch/s_data/s_err   sample input
//   clear              synchronous clear of stats and FIFO
//   rd_ch/rd_bin       readout select; txn_count..hist_count registered (latency 1)
//   bad_ch_cnt         samples on channels >= NUM_CH (live counter)
//   f_valid/f_data/f_ch/f_ready  show-ahead FIFO of good samples
//   f_drops            entries overwritten while full (live counter)

// Per-channel statistics.
module stream_stats_ch #(
  parameter int DATA_W        = 8,
  parameter int HIST_BINS     = 16,
  parameter int HIST_W        = 16,
  parameter int CNT_W         = 32,
  parameter int SUM_W         = 32,
  parameter int MIN_SKIP_ZERO = 1
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              upd,
  input  logic                              err,
  input  logic [DATA_W-1:0]                 data,
  output logic [CNT_W-1:0]                  txn,
  output logic [CNT_W-1:0]                  errc,
  output logic [SUM_W-1:0]                  sum,
  output logic [DATA_W-1:0]                 maxv,
  output logic [DATA_W-1:0]                 minv,
  output logic [HIST_BINS-1:0][HIST_W-1:0]  hist
);
  localparam int BIN_W = $clog2(HIST_BINS);
  // One extra bit catches the carry for sum saturation.
  localparam int AW = ((SUM_W > DATA_W) ? SUM_W : DATA_W) + 1;

  logic [AW-1:0]    sum_nx;
  logic [BIN_W-1:0] bin;
  assign sum_nx = AW'(sum) + AW'(data);
  assign bin    = data[BIN_W-1:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      txn  <= '0;
      errc <= '0;
      sum  <= '0;
      maxv <= '0;
      minv <= '1;
      hist <= '0;
    end else if (upd) begin
      if (~&txn) txn <= txn + 1'b1;
      if (err) begin
        if (~&errc) errc <= errc + 1'b1;
      end else begin
        sum <= (sum_nx > AW'({SUM_W{1'b1}})) ? '1 : sum_nx[SUM_W-1:0];
        if (data > maxv) maxv <= data;
        if (data < minv && !(MIN_SKIP_ZERO != 0 && data == '0)) minv <= data;
        if (~&hist[bin]) hist[bin] <= hist[bin] + 1'b1;
      end
    end
  end
endmodule

module stream_stats_monitor #(
  parameter int DATA_W        = 8,
  parameter int NUM_CH        = 4,
  parameter int HIST_BINS     = 16,
  parameter int HIST_W        = 16,
  parameter int CNT_W         = 32,
  parameter int SUM_W         = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int MIN_SKIP_ZERO = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BIN_W = $clog2(HIST_BINS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_err,
  input  logic              clear,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [BIN_W-1:0]  rd_bin,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [SUM_W-1:0]  data_sum,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [HIST_W-1:0] hist_count,
  output logic [CNT_W-1:0]  bad_ch_cnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  output logic [CH_W-1:0]   f_ch,
  input  logic              f_ready,
  output logic [CNT_W-1:0]  f_drops
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } fent_t;

  typedef enum logic [1:0] {F_EMPTY, F_PARTIAL, F_FULL} fst_t;

  logic clr_all, ch_ok, acc, push, pop;
  assign clr_all = rst | clear;
  assign ch_ok   = 32'(s_ch) < NUM_CH;
  // Clear/reset wins over a same-cycle sample.
  assign acc     = s_valid & ch_ok & ~clr_all;
  assign push    = acc & ~s_err;
  assign pop     = f_valid & f_ready;

  logic [NUM_CH-1:0][CNT_W-1:0]                 txn_a, err_a;
  logic [NUM_CH-1:0][SUM_W-1:0]                 sum_a;
  logic [NUM_CH-1:0][DATA_W-1:0]                max_a, min_a;
  logic [NUM_CH-1:0][HIST_BINS-1:0][HIST_W-1:0] hist_a;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stream_stats_ch #(
      .DATA_W(DATA_W), .HIST_BINS(HIST_BINS), .HIST_W(HIST_W),
      .CNT_W(CNT_W), .SUM_W(SUM_W), .MIN_SKIP_ZERO(MIN_SKIP_ZERO)
    ) u_ch (
      .clk (clk),
      .clr (clr_all),
      .upd (acc && 32'(s_ch) == g),
      .err (s_err),
      .data(s_data),
      .txn (txn_a[g]),
      .errc(err_a[g]),
      .sum (sum_a[g]),
      .maxv(max_a[g]),
      .minv(min_a[g]),
      .hist(hist_a[g])
    );
  end

  // Readout captures the pre-update state at the edge; an out-of-range
  // rd_ch reads back as the cleared state.
  always_ff @(posedge clk) begin
    if (clr_all || !(32'(rd_ch) < NUM_CH)) begin
      txn_count  <= '0;
      err_count  <= '0;
      data_sum   <= '0;
      max_val    <= '0;
      min_val    <= '1;
      hist_count <= '0;
    end else begin
      txn_count  <= txn_a[rd_ch];
      err_count  <= err_a[rd_ch];
      data_sum   <= sum_a[rd_ch];
      max_val    <= max_a[rd_ch];
      min_val    <= min_a[rd_ch];
      hist_count <= hist_a[rd_ch][rd_bin];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_all)                          bad_ch_cnt <= '0;
    else if (s_valid && !ch_ok && ~&bad_ch_cnt) bad_ch_cnt <= bad_ch_cnt + 1'b1;
  end

  // Recent-sample FIFO, overwrite-oldest when full.
  fent_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   cnt, cnt_nx;
  fst_t             fst;
  logic             head_inc, drop;

  always_comb begin
    cnt_nx   = cnt;
    head_inc = pop;
    drop     = 1'b0;
    if (push && !pop) begin
      if (fst == F_FULL) begin
        drop     = 1'b1;
        head_inc = 1'b1;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end else if (!push && pop) begin
      cnt_nx = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_all) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      fst     <= F_EMPTY;
      f_valid <= 1'b0;
      f_drops <= '0;
    end else begin
      if (push)     tail <= tail + 1'b1;
      if (head_inc) head <= head + 1'b1;
      if (drop && ~&f_drops) f_drops <= f_drops + 1'b1;
      cnt     <= cnt_nx;
      f_valid <= cnt_nx != '0;
      if (cnt_nx == '0)                          fst <= F_EMPTY;
      else if (cnt_nx == (PTR_W+1)'(FIFO_DEPTH)) fst <= F_FULL;
      else                                       fst <= F_PARTIAL;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{ch: s_ch, data: s_data};
  end

  assign f_data = mem[head].data;
  assign f_ch   = mem[head].ch;
endmodule

// File: tb/tb_stream_stats_monitor.sv
module tb_stream_stats_monitor;
  localparam int NCH = 5, CMAX = 255, SMAX = 255, HMAX = 3, DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_err, clear, f_ready;
  logic [2:0] s_ch, rd_ch;
  logic [7:0] s_data;
  logic [3:0] rd_bin;
  logic [7:0] txn_count, err_count, data_sum, max_val, min_val, bad_ch_cnt, f_data, f_drops;
  logic [1:0] hist_count;
  logic       f_valid;
  logic [2:0] f_ch;

  stream_stats_monitor #(
    .DATA_W(8), .NUM_CH(NCH), .HIST_BINS(16), .HIST_W(2), .CNT_W(8),
    .SUM_W(8), .FIFO_DEPTH(DEPTH), .MIN_SKIP_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
    .s_err(s_err), .clear(clear), .rd_ch(rd_ch), .rd_bin(rd_bin),
    .txn_count(txn_count), .err_count(err_count), .data_sum(data_sum),
    .max_val(max_val), .min_val(min_val), .hist_count(hist_count),
    .bad_ch_cnt(bad_ch_cnt), .f_valid(f_valid), .f_data(f_data), .f_ch(f_ch),
    .f_ready(f_ready), .f_drops(f_drops)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: plain per-channel totals and a queue of recent samples.
  int m_txn[NCH], m_err[NCH], m_sum[NCH], m_max[NCH], m_min[NCH];
  int m_hist[NCH][16];
  int m_bad, m_drops;
  int fq_d[$], fq_c[$];

  function automatic int sat(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic mreset();
    for (int c = 0; c < NCH; c++) begin
      m_txn[c] = 0; m_err[c] = 0; m_sum[c] = 0; m_max[c] = 0; m_min[c] = 255;
      for (int b = 0; b < 16; b++) m_hist[c][b] = 0;
    end
    m_bad = 0; m_drops = 0;
    fq_d.delete(); fq_c.delete();
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model takes the same inputs, then all outputs are compared.
  task automatic tick();
    int e_txn, e_err, e_sum, e_max, e_min, e_hist, c, d;
    bit push, pop;
    @(posedge clk);
    if (rst || clear) begin
      e_txn = 0; e_err = 0; e_sum = 0; e_max = 0; e_min = 255; e_hist = 0;
      mreset();
    end else begin
      e_txn = m_txn[rd_ch]; e_err = m_err[rd_ch]; e_sum = m_sum[rd_ch];
      e_max = m_max[rd_ch]; e_min = m_min[rd_ch]; e_hist = m_hist[rd_ch][rd_bin];
      pop  = (fq_d.size() > 0) && f_ready;
      push = 1'b0;
      c = int'(s_ch); d = int'(s_data);
      if (s_valid) begin
        if (c >= NCH) m_bad = sat(m_bad + 1, CMAX);
        else begin
          m_txn[c] = sat(m_txn[c] + 1, CMAX);
          if (s_err) m_err[c] = sat(m_err[c] + 1, CMAX);
          else begin
            m_sum[c] = sat(m_sum[c] + d, SMAX);
            if (d > m_max[c]) m_max[c] = d;
            if (d != 0 && d < m_min[c]) m_min[c] = d;
            m_hist[c][d % 16] = sat(m_hist[c][d % 16] + 1, HMAX);
            push = 1'b1;
          end
        end
      end
      if (pop) begin void'(fq_d.pop_front()); void'(fq_c.pop_front()); end
      if (push) begin
        if (fq_d.size() == DEPTH) begin
          void'(fq_d.pop_front()); void'(fq_c.pop_front());
          m_drops = sat(m_drops + 1, CMAX);
        end
        fq_d.push_back(d); fq_c.push_back(c);
      end
    end
    #1;
    chk("txn_count", txn_count, e_txn);
    chk("err_count", err_count, e_err);
    chk("data_sum", data_sum, e_sum);
    chk("max_val", max_val, e_max);
    chk("min_val", min_val, e_min);
    chk("hist_count", hist_count, e_hist);
    chk("bad_ch_cnt", bad_ch_cnt, m_bad);
    chk("f_drops", f_drops, m_drops);
    chk("f_valid", f_valid, fq_d.size() > 0);
    if (fq_d.size() > 0) begin
      chk("f_data", f_data, fq_d[0]);
      chk("f_ch", f_ch, fq_c[0]);
    end
  endtask

  task automatic sample(int c, int d, bit e);
    s_valid = 1'b1; s_ch = 3'(c); s_data = 8'(d); s_err = e;
    tick();
    s_valid = 1'b0; s_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_err = 1'b0; s_ch = '0;
    s_data = '0; rd_ch = '0; rd_bin = '0; f_ready = 1'b0;
    mreset();

    // T1 reset held for two cycles
    tick(); tick();
    rst = 1'b0;
    chk("t1_min", min_val, 8'hFF);
    chk("t1_fvalid", f_valid, 1'b0);
    chk("t1_txn", txn_count, 0);

    // T2 channel-1 stats
    rd_ch = 3'd1; rd_bin = 4'd3;
    sample(1, 8'h03, 0); sample(1, 8'h0A, 0); sample(1, 8'h00, 0); sample(1, 8'h13, 0);
    tick();
    chk("t2_txn", txn_count, 4);
    chk("t2_sum", data_sum, 8'h20);
    chk("t2_max", max_val, 8'h13);
    chk("t2_min", min_val, 8'h03);
    chk("t2_hist", hist_count, 2);

    // T3 error sample and out-of-range channel
    rd_ch = 3'd2;
    sample(2, 8'h55, 1); sample(5, 8'h11, 0);
    tick();
    chk("t3_err", err_count, 1);
    chk("t3_sum", data_sum, 0);
    chk("t3_bad", bad_ch_cnt, 1);

    // clear with a same-cycle sample: sample must be discarded
    clear = 1'b1; sample(0, 8'h09, 0); clear = 1'b0;
    rd_ch = 3'd0; tick();
    chk("clr_txn", txn_count, 0);
    chk("clr_fvalid", f_valid, 1'b0);

    // T4 FIFO overflow then drain
    for (int i = 1; i <= 10; i++) sample(0, i, 0);
    chk("t4_drops", f_drops, 2);
    f_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_pop_data", f_data, 3 + i);
      tick();
    end
    chk("t4_fvalid_low", f_valid, 1'b0);
    f_ready = 1'b0;

    // T5 push and pop while full
    for (int i = 0; i < 8; i++) sample(2, 8'h20 + i, 0);
    f_ready = 1'b1; sample(2, 8'h77, 0);
    chk("t5_drops", f_drops, 2);
    for (int i = 0; i < 7; i++) tick();
    chk("t5_last", f_data, 8'h77);
    tick();
    chk("t5_empty", f_valid, 1'b0);
    f_ready = 1'b0;

    // T6 saturation, then clear with sample
    rd_ch = 3'd3; rd_bin = 4'd5;
    for (int i = 0; i < 5; i++) sample(3, 8'h05, 0);
    sample(3, 8'hF0, 0); sample(3, 8'hF0, 0);
    tick();
    chk("t6_hist_sat", hist_count, 3);
    chk("t6_sum_sat", data_sum, 8'hFF);
    clear = 1'b1; sample(3, 8'h05, 0); clear = 1'b0;
    tick();
    chk("t6_clr_sum", data_sum, 0);
    chk("t6_clr_hist", hist_count, 0);
    chk("t6_clr_min", min_val, 8'hFF);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 59) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_ch    = 3'($urandom_range(0, 7));
      s_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      s_err   = ($urandom_range(0, 5) == 0);
      rd_ch   = 3'($urandom_range(0, NCH - 1));
      rd_bin  = 4'($urandom);
      f_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
